// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a bit-timer FSM that sends bytes LSB first, back-to-back.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD picks odd/even sense).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BIT_LAST = 16'(DIVISOR - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIVISOR < 1 ||
      DIVISOR > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Reset asserts at once but releases on a clock edge, two flops deep.
  logic rst_meta_q, rst_core_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rst_meta_q, rst_core_q} <= 2'b11;
    else     {rst_meta_q, rst_core_q} <= {1'b0, rst_meta_q};
  end

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, fifo_nonempty;

  state_t      state_q;
  logic [15:0] clk_count_q;
  logic [2:0]  bit_count_q;
  logic [7:0]  shift_q;
  logic        tx_out_q;
  logic        bit_end;

  assign fifo_nonempty = (count_q != '0);
  assign tx_ready      = (count_q != FULL_CNT);
  assign push          = tx_valid && tx_ready;
  assign bit_end       = (clk_count_q == BIT_LAST);
  assign pop           = fifo_nonempty &&
                         ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the byte storage carries no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst_core_q) begin
    if (rst_core_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst_core_q) begin
    if (rst_core_q) begin
      state_q     <= S_IDLE;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      tx_out_q    <= 1'b1;
    end else begin
      if (state_q == S_IDLE || bit_end) clk_count_q <= '0;
      else                               clk_count_q <= clk_count_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          tx_out_q <= 1'b1;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            tx_out_q <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_out_q    <= shift_q[0];
            bit_count_q <= '0;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_count_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_out_q <= (^shift_q) ^ 1'(PARITY_ODD);
              state_q  <= S_PARITY;
`else
              tx_out_q <= 1'b1;
              state_q  <= S_STOP;
`endif
            end else begin
              bit_count_q <= bit_count_q + 3'd1;
              tx_out_q    <= shift_q[bit_count_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx_out_q <= 1'b1;
            state_q  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // A queued byte starts its start bit on the very edge the stop bit ends.
          if (bit_end) begin
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
              tx_out_q <= 1'b0;
              state_q  <= S_START;
            end else begin
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_busy    = (state_q != S_IDLE) || fifo_nonempty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIVISOR=16, FIFO_DEPTH=4, with a loopback receiver.
module tb_uart_tx_fifo;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CYC  = 176;
`else
  localparam int FRAME_BITS = 10;
  localparam int FRAME_CYC  = 160;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, tx_busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10),
    .FIFO_DEPTH(4),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level of bit k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Loopback receiver: samples each bit in its middle, records byte and start cycle.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  bit         rx_en = 1'b0;
  int         rx_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && tx_out === 1'b0) begin
        int         st;
        logic [7:0] b;
        st = cyc;
        repeat (DIV/2) @(negedge clk);
        if (tx_out !== 1'b0) rx_err++;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = tx_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        if (tx_out !== ^b) rx_err++;
`endif
        repeat (DIV) @(negedge clk);
        if (tx_out !== 1'b1) rx_err++;
        rx_q.push_back(b);
        rx_start.push_back(st);
      end
    end
  end

  // Byte is accepted on the posedge following the negedge where it is driven.
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (tx_busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_idle_timeout"}, 32'(guard >= 3000), 32'd0);
  endtask

  // Push one byte into an idle DUT and check every cycle of its frame.
  task automatic frame_check(input logic [7:0] b);
    int errs[11];
    logic busy_last, busy_after, line_first;
    for (int k = 0; k < 11; k++) errs[k] = 0;
    push(b);
    for (int n = 0; n <= FRAME_CYC + 1; n++) begin
      @(negedge clk);
      if (n == 0) line_first = tx_out;
      else if (n <= FRAME_CYC) begin
        if (tx_out !== frame_bit(b, (n - 1) / DIV)) errs[(n - 1) / DIV]++;
      end
      if (n == FRAME_CYC)     busy_last  = tx_busy;
      if (n == FRAME_CYC + 1) busy_after = tx_busy;
    end
    check($sformatf("frame_%02h_line_before_start", b), 32'(line_first), 32'd1);
    for (int k = 0; k < FRAME_BITS; k++)
      check($sformatf("frame_%02h_bit%0d_bad_cycles", b, k), 32'(errs[k]), 32'd0);
    check($sformatf("frame_%02h_busy_last_cycle", b), 32'(busy_last), 32'd1);
    check($sformatf("frame_%02h_busy_dropped", b), 32'(busy_after), 32'd0);
  endtask

  initial begin
    logic [7:0] v3 [6];
    int         acc [6];
    int         edge_n, guard, zeros, busies;
    bit         timed_out;

    // 1: reset, then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("reset_tx_out", 32'(tx_out), 32'd1);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);

    // 2: single byte 0xA5, bit-exact frame and busy timing
    frame_check(8'hA5);

    // 3: stream with valid held high; sixth byte waits for a pop
    wait_idle("t3");
    v3 = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55, 8'h99};
    rx_q.delete();
    rx_start.delete();
    rx_en = 1'b1;
    timed_out = 1'b0;
    @(negedge clk);
    edge_n = 0;
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = v3[i];
      if (i == 5) begin
        check("t3_full_ready", 32'(tx_ready), 32'd0);
        check("t3_full_count", 32'(fifo_count), 32'd4);
      end
      guard = 0;
      while (!tx_ready && guard < 400) begin
        @(negedge clk);
        edge_n++;
        guard++;
      end
      if (guard >= 400) timed_out = 1'b1;
      acc[i] = edge_n;
      @(negedge clk);
      edge_n++;
    end
    tx_valid = 1'b0;
    check("t3_accept_timeout", 32'(timed_out), 32'd0);
    check("t3_fifth_accept_edge", 32'(acc[4]), 32'd4);
    check("t3_sixth_accept_edge", 32'(acc[5]), 32'd162);
    wait_idle("t3");
    repeat (40) @(negedge clk);
    rx_en = 1'b0;
    check("t3_rx_count", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("t3_rx_byte%0d", i), 32'(rx_q[i]), 32'(v3[i]));
    for (int i = 1; i < rx_start.size(); i++)
      check($sformatf("t3_gap%0d", i), 32'(rx_start[i] - rx_start[i-1]), 32'(FRAME_CYC));

    // 4: reset in the middle of bit 2 of 0xF0 with two bytes queued
    push(8'hF0);
    push(8'h11);
    push(8'h22);
    repeat (55) @(posedge clk);
    @(negedge clk);
    check("t4_pre_line_low", 32'(tx_out), 32'd0);
    check("t4_pre_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_tx_out", 32'(tx_out), 32'd1);
    check("t4_rst_count", 32'(fifo_count), 32'd0);
    check("t4_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    busies = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_out !== 1'b1) zeros++;
      if (tx_busy !== 1'b0) busies++;
    end
    check("t4_post_line_low_cycles", 32'(zeros), 32'd0);
    check("t4_post_busy_cycles", 32'(busies), 32'd0);
    check("t4_post_count", 32'(fifo_count), 32'd0);

    // 5: push on the same edge the STOP bit of the first byte pops the next
    rx_q.delete();
    rx_start.delete();
    rx_en = 1'b1;
    push(8'h12);
    push(8'h34);
    push(8'h56);
    repeat (158) @(posedge clk);
    @(negedge clk);
    check("t5_count_before", 32'(fifo_count), 32'd2);
    tx_data  = 8'h78;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    check("t5_count_after", 32'(fifo_count), 32'd2);
    check("t5_next_start_bit", 32'(tx_out), 32'd0);
    wait_idle("t5");
    repeat (40) @(negedge clk);
    rx_en = 1'b0;
    check("t5_rx_count", 32'(rx_q.size()), 32'd4);
    if (rx_q.size() == 4) begin
      check("t5_rx_byte0", 32'(rx_q[0]), 32'h12);
      check("t5_rx_byte1", 32'(rx_q[1]), 32'h34);
      check("t5_rx_byte2", 32'(rx_q[2]), 32'h56);
      check("t5_rx_byte3", 32'(rx_q[3]), 32'h78);
    end
    check("rx_framing_errors", 32'(rx_err), 32'd0);

    // 6: 0x07 frame length (and parity bit when enabled)
    frame_check(8'h07);
`ifdef UART_TX_PARITY_EN
    check("t6_parity_bit_07", 32'(frame_bit(8'h07, 9)), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
